effect_param_controller: RTL
============================

# effect_param_controller

Multi-channel, parametrised successor to the single-rate tremolo key controller. Debounces the two board keys, steps a per-channel clock divisor up or down with saturation, and recomputes each channel's effect rate as `CLK_HZ / divisor` using a shared sequential divider. The divider replaces combinational division. Sits between the board keys/switches and the effect modules (tremolo, vibrato and similar), which consume `frequency` and `disabled`.

## Interface
- `CLK_HZ`, 50000000: system clock rate, and the dividend for rate computation.
- `NUM_CH`, 4: number of independent effect-rate channels (1..16).
- `DIV_W`, 16: divisor register width.
- `FREQ_W`, 32: width of each frequency output.
- `DIV_INIT`, 2560: divisor value at reset.
- `DIV_STEP`, 256: divisor increment/decrement per key press.
- `DIV_MIN`, 256 / `DIV_MAX`, 5120: saturation limits, with DIV_MIN > 0.
- `DEBOUNCE`, 50000: consecutive stable cycles required to accept a key level.
- `SEL_CODE`, 2: value of `SW[3:0]` that enables key editing.
- `CLK`  in  1: system clock, rising edge.
- `RST_N`  in  1: asynchronous, active-low reset.
- `key_up`  in  1: raw key, active-low; a press lowers the divisor and so raises the rate.
- `key_down`  in  1: raw key, active-low; a press raises the divisor and so lowers the rate.
- `SW`  in  10: `[3:0]` mode code, `[7:4]` channel select, `[8]` effect enable.
- `disabled`  out  1: registered `~SW[8]`.
- `frequency`  out  NUM_CH*FREQ_W: channel c occupies bits `[c*FREQ_W +: FREQ_W]`.
- `busy`  out  1: high while the divider is running or any channel recompute is pending.

## Operation
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - All divisors = DIV_INIT.
  - All `frequency` = CLK_HZ/DIV_INIT, an elaboration-time constant (19531 with defaults).
  - `disabled` = 1, `busy` = 0.
  - Pending mask = 0; debouncers stable-high with counters at 0.
- Key input path: each key passes through a 2-FF synchroniser, then a debouncer.
  - The debouncer counter increments while the synced level differs from the stable level.
  - It clears when the two levels agree.
  - When the count reaches DEBOUNCE, the stable level flips and the counter clears.
- Press event: a single-cycle pulse on a stable 1→0 transition. Releases generate nothing.
- Events are accepted only when `SW[3:0]==SEL_CODE` and `SW[7:4] < NUM_CH`. Otherwise they are dropped with no side effects.
- Simultaneous up and down events in the same cycle are both dropped.
- Up event on channel c: `div_c = max(div_c - DIV_STEP, DIV_MIN)`.
- Down event on channel c: `div_c = min(div_c + DIV_STEP, DIV_MAX)`.
  - Arithmetic is done in DIV_W+1 bits, so no wrap occurs.
- If the divisor actually changed, set `pending[c]`. An event at a limit leaves both the divisor and `pending` unchanged.
- Divider FSM:
  - IDLE: if `pending` is nonzero, latch the lowest set channel index k and the current `div_k`, clear `pending[k]`, and go to DIV.
  - DIV: restoring division, one quotient bit per cycle, FREQ_W iterations, dividend CLK_HZ. When done, go to WB.
  - WB: write the truncated quotient to `frequency[k]`, then return to IDLE.
- Divisor changes to channel k during DIV set `pending[k]` again. The stale result is still written in WB, and the new value is recomputed afterwards.
- `busy = (state != IDLE) | (|pending)`.
- `frequency` outputs of channels that are not being written hold their values.
- `disabled` updates every cycle, independent of SEL_CODE and of the FSM.
- Reset asserted mid-division: the FSM returns to IDLE and every register returns to its reset value. No partial result is written.

## Timing
- Key level change to press event: 2 sync cycles + DEBOUNCE cycles + 1 cycle.
- Divisor register updates 1 cycle after the event.
- IDLE→DIV: 1 cycle. DIV: FREQ_W cycles. WB: 1 cycle.
  - From the divisor update to the new `frequency` value: FREQ_W+2 cycles when the divider is idle (34 cycles with defaults).
- N channels pending together complete in N*(FREQ_W+2) cycles, serviced in ascending index order.
- `disabled` lags `SW[8]` by 1 cycle.

## Test plan
- Reset: with DEBOUNCE=4, assert `RST_N`=0 → all `frequency` = 19531, `disabled`=1, `busy`=0. Release and set SW[8]=1 → `disabled`=0 one cycle later.
- Up press, channel 1: SW=0x112, one up press → `div1`=2304 and `frequency[1]`=21701 after 34 cycles; other channels stay at 19531.
- Saturation: 9 up presses on channel 0 → divisor 256, frequency 195312. A 10th press → no change and `busy` stays 0. Down presses from 5120 behave the same way at the upper limit.
- Bounce rejection: key toggling every 2 cycles for 20 cycles, then held low → exactly one event. Holding then releasing the key produces no second event.
- Mode gating and collision:
  - `SW[3:0]`=1 with presses → no change.
  - `SW[7:4]`=5 with NUM_CH=4 → no change.
  - Up and down presses on the same cycle → no change.
- Queued recompute and mid-operation reset:
  - Presses on channels 2 and 0 during one DIV → each result lands in ascending order and `busy` falls after the final WB.
  - `RST_N` pulsed low mid-DIV → `frequency` stays at reset values.

Source files
------------

// File: rtl/effect_param_controller.sv
// effect_param_controller
//   Debounces the two board keys and steps a per-channel clock divisor up or down.
//   The divisor saturates at DIV_MIN and DIV_MAX. Each channel's effect rate,
//   CLK_HZ / divisor, is recomputed by one shared restoring divider.
//
// Ports
//   CLK        system clock, rising edge
//   RST_N      asynchronous active-low reset
//   key_up     raw key, active-low; a press lowers the divisor (raises the rate)
//   key_down   raw key, active-low; a press raises the divisor (lowers the rate)
//   SW[3:0]    mode code; edits are accepted only when it equals SEL_CODE
//   SW[7:4]    channel select
//   SW[8]      effect enable (inverted and registered onto 'disabled')
//   disabled   registered ~SW[8]
//   frequency  NUM_CH packed rates; channel c is [c*FREQ_W +: FREQ_W]
//   busy       divider running or a channel recompute pending
module effect_param_controller #(
    parameter int CLK_HZ   = 50000000,
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 16,
    parameter int FREQ_W   = 32,
    parameter int DIV_INIT = 2560,
    parameter int DIV_STEP = 256,
    parameter int DIV_MIN  = 256,
    parameter int DIV_MAX  = 5120,
    parameter int DEBOUNCE = 50000,
    parameter int SEL_CODE = 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     key_up,
    input  logic                     key_down,
    input  logic [9:0]               SW,
    output logic                     disabled,
    output logic [NUM_CH*FREQ_W-1:0] frequency,
    output logic                     busy
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int BIT_W = $clog2(FREQ_W + 1);
    localparam int DW1   = DIV_W + 1;

    localparam logic [FREQ_W-1:0] DIVIDEND   = FREQ_W'(CLK_HZ);
    localparam logic [FREQ_W-1:0] FREQ_INIT  = FREQ_W'(CLK_HZ / DIV_INIT);
    localparam logic [DIV_W-1:0]  DIV_INIT_V = DIV_W'(DIV_INIT);
    localparam logic [DIV_W:0]    MIN_EXT    = DW1'(DIV_MIN);
    localparam logic [DIV_W:0]    MAX_EXT    = DW1'(DIV_MAX);
    localparam logic [DIV_W:0]    STEP_EXT   = DW1'(DIV_STEP);
    localparam logic [DIV_W:0]    MIN_PLUS   = DW1'(DIV_MIN + DIV_STEP);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_WB} state_t;

    // Key path: index 0 = key_up, index 1 = key_down.
    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       stable_q, stable_d, stable_prev_q, stable_prev_d;
    logic [1:0]       press_q, press_d;
    logic [CNT_W-1:0] db_cnt_q [2];
    logic [CNT_W-1:0] db_cnt_d [2];

    logic [3:0] sw_mode, sw_ch;
    logic       accept, ev_up, ev_dn;
    logic       unused_sw9;

    logic [DIV_W-1:0]  div_q  [NUM_CH];
    logic [DIV_W-1:0]  div_d  [NUM_CH];
    logic [FREQ_W-1:0] freq_q [NUM_CH];
    logic [FREQ_W-1:0] freq_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d, pend_set, pend_clr;
    logic [DIV_W:0]    cur, step_val;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [DIV_W-1:0]  dvsr_q, dvsr_d;
    logic [DIV_W-1:0]  rem_q, rem_d;
    logic [DIV_W:0]    rem_sh;
    logic [FREQ_W-1:0] quo_q, quo_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              disabled_q, disabled_d;

    assign sw_mode    = SW[3:0];
    assign sw_ch      = SW[7:4];
    assign unused_sw9 = SW[9];
    assign accept     = (sw_mode == 4'(SEL_CODE)) && ({1'b0, sw_ch} < 5'(NUM_CH));
    // Simultaneous up and down presses cancel each other.
    assign ev_up      = press_q[0] & ~press_q[1] & accept;
    assign ev_dn      = press_q[1] & ~press_q[0] & accept;

    // Synchroniser and debouncer; the press pulse comes one cycle after the stable level falls.
    always_comb begin
        sync1_d       = {key_down, key_up};
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        press_d    = stable_prev_q & ~stable_q;
        disabled_d = ~SW[8];
    end

    // Saturating divisor edit. The compare is done before subtracting so that
    // small divisors cannot wrap.
    always_comb begin
        div_d    = div_q;
        pend_set = '0;
        cur      = '0;
        step_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((ev_up || ev_dn) && (sw_ch == 4'(c))) begin
                cur = {1'b0, div_q[c]};
                if (ev_up) begin
                    step_val = (cur <= MIN_PLUS) ? MIN_EXT : cur - STEP_EXT;
                end else begin
                    step_val = (cur + STEP_EXT >= MAX_EXT) ? MAX_EXT : cur + STEP_EXT;
                end
                div_d[c]    = step_val[DIV_W-1:0];
                pend_set[c] = (step_val != cur);
            end
        end
    end

    // Divider FSM: pick the lowest pending channel, run FREQ_W restoring steps, write back.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        bit_d    = bit_q;
        freq_d   = freq_q;
        pend_clr = '0;
        rem_sh   = '0;
        case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    for (int c = NUM_CH - 1; c >= 0; c--) begin
                        if (pend_q[c]) begin
                            sel_d       = CH_W'(c);
                            dvsr_d      = div_q[c];
                            pend_clr    = '0;
                            pend_clr[c] = 1'b1;
                        end
                    end
                    rem_d   = '0;
                    quo_d   = DIVIDEND;
                    bit_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                // The dividend shifts out of quo's MSB while quotient bits shift into its LSB.
                rem_sh = {rem_q, quo_q[FREQ_W-1]};
                if (rem_sh >= {1'b0, dvsr_q}) begin
                    rem_d = DIV_W'(rem_sh - {1'b0, dvsr_q});
                    quo_d = {quo_q[FREQ_W-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[DIV_W-1:0];
                    quo_d = {quo_q[FREQ_W-2:0], 1'b0};
                end
                bit_d = bit_q + 1'b1;
                if (bit_q == BIT_W'(FREQ_W - 1)) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (sel_q == CH_W'(c)) begin
                        freq_d[c] = quo_q;
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A new edit on the channel being latched re-arms its pending bit.
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            stable_q      <= '1;
            stable_prev_q <= '1;
            press_q       <= '0;
            db_cnt_q[0]   <= '0;
            db_cnt_q[1]   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                div_q[c]  <= DIV_INIT_V;
                freq_q[c] <= FREQ_INIT;
            end
            pend_q     <= '0;
            state_q    <= S_IDLE;
            sel_q      <= '0;
            dvsr_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            bit_q      <= '0;
            disabled_q <= 1'b1;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            press_q       <= press_d;
            db_cnt_q[0]   <= db_cnt_d[0];
            db_cnt_q[1]   <= db_cnt_d[1];
            div_q         <= div_d;
            freq_q        <= freq_d;
            pend_q        <= pend_d;
            state_q       <= state_d;
            sel_q         <= sel_d;
            dvsr_q        <= dvsr_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            bit_q         <= bit_d;
            disabled_q    <= disabled_d;
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_freq_out
            assign frequency[g*FREQ_W +: FREQ_W] = freq_q[g];
        end
    endgenerate

    assign disabled = disabled_q;
    assign busy     = (state_q != S_IDLE) | (|pend_q);

endmodule
